uart_autobaud: RTL
==================

# uart_autobaud

Automatic baud-rate detector for the UART receive path. It watches the raw serial line after being armed, measures the width of low pulses in a host-sent 0x55 calibration character, and classifies them against the four supported rates. When enough pulses agree, it drives the `baud_sel` code consumed by the baud generator. It is the measuring counterpart of the baud generator and sits between the RX pin and the generator's `baud_sel` input.

## Interface
Parameters:
- `BIT_2400`, default 41667: nominal bit period in `clk_in` cycles (100 MHz clock).
- `BIT_9600`, default 10417: nominal bit period in cycles.
- `BIT_19200`, default 5208: nominal bit period in cycles.
- `BIT_38400`, default 2604: nominal bit period in cycles.
- `N_MATCH`, default 4: number of consecutive agreeing low pulses required to lock (range 1–5).
- `TOL_SHIFT`, default 3: tolerance is `nom >> TOL_SHIFT` (±12.5%).

Ports:
- `clk_in`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rx_in`, input, 1: raw serial line, asynchronous to `clk_in`.
- `arm`, input, 1: single-cycle pulse that starts or restarts detection.
- `baud_sel`, output, 2: detected rate code (0 = 2400, 1 = 9600, 2 = 19200, 3 = 38400). Reset value 1.
- `locked`, output, 1: a valid rate has been detected since the last `arm`. Reset value 0.
- `det_done`, output, 1: one-cycle pulse when lock is achieved. Reset value 0.
- `det_err`, output, 1: one-cycle pulse on a rejected pulse or a break. Reset value 0.

## Operation
- `rx_in` passes through a 2-flop synchronizer. All logic uses the synchronized `rx_s`. Edges are detected against a registered copy of `rx_s`.
- Low-width counter is 17 bits, saturating at 2^17−1.
- Classification window for each rate is [nom − (nom>>TOL_SHIFT), nom + (nom>>TOL_SHIFT)]. Windows do not overlap.
- FSM states:
  - IDLE: waiting for `arm`.
  - WAIT_IDLE: `rx_s` must be high for `BIT_38400` consecutive cycles. Any low restarts the count.
  - WAIT_FALL: wait for a falling edge of `rx_s`; counter clears.
  - MEASURE: counter increments each cycle while `rx_s` is low.
  - LOCKED: result held.
- MEASURE exits:
  - On a rising edge, classify the count.
  - If the first pulse is in a window: store its class and set match count to 1.
  - If a later pulse has the same class: increment match count.
  - If match count reaches `N_MATCH`: go to LOCKED.
  - Otherwise return to WAIT_FALL.
- Errors:
  - Out-of-window pulse, or a class different from the stored class: pulse `det_err`, clear match count, go to WAIT_IDLE.
  - Break (count exceeds the 2400 upper bound, 46875, while still low): pulse `det_err` immediately, go to WAIT_IDLE.
- LOCKED: `baud_sel` takes the stored class, `locked` is 1, `det_done` pulses. The block stays in LOCKED until the next `arm`.
- `arm` in any state:
  - Clears `locked` and the match count and enters WAIT_IDLE on the next cycle.
  - `baud_sel` retains its last value, so the generator keeps running.
- `arm` coincident with the lock-completing edge: `arm` wins. No `det_done`, `locked` stays 0.
- Reset asserted mid-measurement: all state returns to reset values immediately (asynchronous).

## Timing
- Synchronizer latency: 2 cycles from `rx_in` to `rx_s`, plus 1 cycle for edge detection.
- Measured count equals the number of cycles `rx_s` is low, exact to ±1 cycle.
- `det_done`, `locked` and `baud_sel` update together on the cycle after the synchronized rising edge of the `N_MATCH`-th pulse.
- Break `det_err` is asserted on the cycle after the count passes 46875.
- `det_done` and `det_err` are never high in the same cycle and never high for more than 1 cycle.

## Structure
- Shared package `uart_pkg` holds:
  - `baud_sel` encoding constants (`BAUD_SEL_2400` … `BAUD_SEL_38400`);
  - nominal bit-period constants, shared with the baud generator;
  - the detector state enum.
- Sub-module `sync_2ff` provides the single-bit two-flop synchronizer, reusable by the receiver.
- Window bounds are computed as constants from the parameters. No runtime division.

## Test plan
- Reset: hold `rst_n` = 0 with `rx_in` toggling. Required: `baud_sel` = 1, `locked` = 0, no pulses. After release, no activity until `arm`.
- Lock at 9600: arm, 20000 cycles of idle high, then 0x55 at 10417 cycles/bit. Required: `det_done` pulses once after the 4th low pulse, `baud_sel` = 1, `locked` = 1.
- Lock at 38400 with skew: 0x55 at 2864 cycles/bit (+10%). Required: `baud_sel` = 3, `locked` = 1. Repeat at 2290 cycles/bit (−12%): same result.
- Rejection then recovery: one 7000-cycle low pulse. Required: `det_err` pulses, `locked` = 0. Then 0x55 at 5208 cycles/bit. Required: `baud_sel` = 2.
- Break and mixed classes:
  - Line held low 50000 cycles: `det_err` about 46876 cycles after the fall, no lock.
  - Two pulses at 10417 cycles then one at 5208: `det_err`, no lock.
- Re-arm and reset mid-operation:
  - Pulse `arm` while locked at 2400: `locked` = 0 next cycle, `baud_sel` stays 0.
  - Assert `rst_n` mid-MEASURE: immediate reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_sel codes, nominal bit periods at 100 MHz,
// and the auto-baud detector state encoding.
package uart_pkg;

   localparam logic [1:0] BAUD_SEL_2400  = 2'd0;
   localparam logic [1:0] BAUD_SEL_9600  = 2'd1;
   localparam logic [1:0] BAUD_SEL_19200 = 2'd2;
   localparam logic [1:0] BAUD_SEL_38400 = 2'd3;

   // Bit periods in 100 MHz clock cycles; also used by the baud generator.
   localparam int NOM_2400  = 41667;
   localparam int NOM_9600  = 10417;
   localparam int NOM_19200 = 5208;
   localparam int NOM_38400 = 2604;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_IDLE,
      ST_WAIT_FALL,
      ST_MEASURE,
      ST_LOCKED
   } det_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Resets to RST_VAL so
// an idle-high serial line does not produce a false edge out of reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud detector: measures low pulses of a 0x55 calibration character and
// locks baud_sel once N_MATCH consecutive pulses fall in the same rate window.
module uart_autobaud
   import uart_pkg::*;
#(
   parameter int BIT_2400  = NOM_2400,
   parameter int BIT_9600  = NOM_9600,
   parameter int BIT_19200 = NOM_19200,
   parameter int BIT_38400 = NOM_38400,
   parameter int N_MATCH   = 4,
   parameter int TOL_SHIFT = 3
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       rx_in,
   input  logic       arm,
   output logic [1:0] baud_sel,
   output logic       locked,
   output logic       det_done,
   output logic       det_err
);

   // Acceptance windows, nom +/- (nom >> TOL_SHIFT), fixed at elaboration.
   localparam logic [16:0] LO_2400  = 17'(BIT_2400  - (BIT_2400  >> TOL_SHIFT));
   localparam logic [16:0] HI_2400  = 17'(BIT_2400  + (BIT_2400  >> TOL_SHIFT));
   localparam logic [16:0] LO_9600  = 17'(BIT_9600  - (BIT_9600  >> TOL_SHIFT));
   localparam logic [16:0] HI_9600  = 17'(BIT_9600  + (BIT_9600  >> TOL_SHIFT));
   localparam logic [16:0] LO_19200 = 17'(BIT_19200 - (BIT_19200 >> TOL_SHIFT));
   localparam logic [16:0] HI_19200 = 17'(BIT_19200 + (BIT_19200 >> TOL_SHIFT));
   localparam logic [16:0] LO_38400 = 17'(BIT_38400 - (BIT_38400 >> TOL_SHIFT));
   localparam logic [16:0] HI_38400 = 17'(BIT_38400 + (BIT_38400 >> TOL_SHIFT));
   localparam logic [16:0] IDLE_LEN = 17'(BIT_38400);
   localparam logic [16:0] CNT_MAX  = '1;
   localparam logic [2:0]  MATCH_N  = 3'(N_MATCH);

   logic        rx_s;
   logic        rx_d;
   logic        fall;
   det_state_t  state, state_nxt;
   logic [16:0] cnt, cnt_nxt;
   logic [1:0]  cls, cls_nxt;
   logic [2:0]  match, match_nxt;
   logic [1:0]  sel_nxt;
   logic        locked_nxt;
   logic        done_nxt;
   logic        err_nxt;
   logic        cls_vld;
   logic [1:0]  cls_cur;
   logic [2:0]  match_inc;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .d      (rx_in),
      .q      (rx_s)
   );

   // Registered copy of the synchronized line for edge detection.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) rx_d <= 1'b1;
      else        rx_d <= rx_s;
   end

   assign fall      = rx_d & ~rx_s;
   assign match_inc = match + 3'd1;

   // Map the current low-width count onto a rate window, if any.
   always_comb begin
      cls_vld = 1'b1;
      cls_cur = BAUD_SEL_9600;
      if (cnt >= LO_2400 && cnt <= HI_2400)
         cls_cur = BAUD_SEL_2400;
      else if (cnt >= LO_9600 && cnt <= HI_9600)
         cls_cur = BAUD_SEL_9600;
      else if (cnt >= LO_19200 && cnt <= HI_19200)
         cls_cur = BAUD_SEL_19200;
      else if (cnt >= LO_38400 && cnt <= HI_38400)
         cls_cur = BAUD_SEL_38400;
      else
         cls_vld = 1'b0;
   end

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Datapath and output registers, loaded from the next-state logic.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         cls      <= BAUD_SEL_9600;
         match    <= '0;
         baud_sel <= BAUD_SEL_9600;
         locked   <= 1'b0;
         det_done <= 1'b0;
         det_err  <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         cls      <= cls_nxt;
         match    <= match_nxt;
         baud_sel <= sel_nxt;
         locked   <= locked_nxt;
         det_done <= done_nxt;
         det_err  <= err_nxt;
      end
   end

   // Next-state and output logic; arm overrides everything, including a
   // lock that would complete in the same cycle.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      cls_nxt    = cls;
      match_nxt  = match;
      sel_nxt    = baud_sel;
      locked_nxt = locked;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;

      if (arm) begin
         state_nxt  = ST_WAIT_IDLE;
         cnt_nxt    = '0;
         match_nxt  = '0;
         locked_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: ;

            // Line must be quiet (high) for one shortest bit period.
            ST_WAIT_IDLE: begin
               if (!rx_s) begin
                  cnt_nxt = '0;
               end else if (cnt >= IDLE_LEN - 17'd1) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_WAIT_FALL;
               end else begin
                  cnt_nxt = cnt + 17'd1;
               end
            end

            // The falling-edge cycle is itself the first low cycle.
            ST_WAIT_FALL: begin
               cnt_nxt = '0;
               if (fall) begin
                  cnt_nxt   = 17'd1;
                  state_nxt = ST_MEASURE;
               end
            end

            ST_MEASURE: begin
               if (!rx_s) begin
                  if (cnt > HI_2400) begin
                     // Longer than any legal bit: treat as break.
                     err_nxt   = 1'b1;
                     match_nxt = '0;
                     cnt_nxt   = '0;
                     state_nxt = ST_WAIT_IDLE;
                  end else if (cnt != CNT_MAX) begin
                     cnt_nxt = cnt + 17'd1;
                  end
               end else begin
                  // Line was low for the whole of MEASURE, so high here is
                  // the rising edge that ends the pulse.
                  cnt_nxt = '0;
                  if (!cls_vld || (match != 3'd0 && cls_cur != cls)) begin
                     err_nxt   = 1'b1;
                     match_nxt = '0;
                     state_nxt = ST_WAIT_IDLE;
                  end else begin
                     cls_nxt   = cls_cur;
                     match_nxt = (match == 3'd0) ? 3'd1 : match_inc;
                     if (match_nxt >= MATCH_N) begin
                        state_nxt  = ST_LOCKED;
                        sel_nxt    = cls_cur;
                        locked_nxt = 1'b1;
                        done_nxt   = 1'b1;
                     end else begin
                        state_nxt = ST_WAIT_FALL;
                     end
                  end
               end
            end

            ST_LOCKED: ;

            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule
